dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU) and a host
//  burst port used for program/data load and result dump.
//  CPU has default priority. The host wins after MAX_WAIT starved cycles; the CPU is then
//  stalled through cpu_stall, which is OR-ed into the hazard unit's Stall.
//  Sits between the datapath MEM stage and the data memory instance.
// PARAMETERS
//  DATA_WIDTH     20  memory word width
//  ADDRESS_WIDTH  8   memory address width (256 words)
//  BURST_WIDTH    8   width of host_len (beats = host_len+1)
//  MAX_WAIT       8   starved host cycles before the CPU is forcibly stalled (>=1)
//  CNT_WIDTH      16  statistics counter width
// PORTS
//  clk             in   1    clock, rising edge
//  rst             in   1    asynchronous reset, active-high
//  cpu_mem_read    in   1    MEM-stage read request
//  cpu_mem_write   in   1    MEM-stage write request
//  cpu_byte_en     in   1    MEM-stage ByteEnable
//  cpu_addr        in   AW   MEM-stage address
//  cpu_wdata       in   DW   MEM-stage store data
//  cpu_rdata       out  DW   = mem_rdata (pass-through)
//  cpu_stall       out  1    CPU access blocked this cycle
//  host_req        in   1    burst request, level
//  host_we         in   1    1 = write burst, 0 = read burst (sampled with request)
//  host_addr       in   AW   burst start address (sampled with request)
//  host_len        in   BW   beats-1 (sampled with request)
//  host_wdata      in   DW   write data, consumed one word per BURST cycle
//  host_gnt        out  1    1-cycle pulse, first BURST cycle
//  host_rvalid     out  1    read beat data valid
//  host_rdata      out  DW   read beat data
//  host_done       out  1    1-cycle pulse, burst finished
//  mem_re/mem_we   out  1    memory strobes
//  mem_byte_en     out  1    memory byte enable
//  mem_addr        out  AW   memory address
//  mem_wdata       out  DW   memory write data
//  mem_rdata       in   DW   memory read data, 1-cycle synchronous latency
//  stat_stall_cnt  out  CW   CPU stall cycles (see CONFIGURATION)
//  stat_beat_cnt   out  CW   host beats issued (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states are IDLE, BURST and DRAIN. Reset: IDLE, all counters 0, all outputs 0.
//  - IDLE: memory bus mirrors CPU combinationally; cpu_stall=0.
//  - cpu_act = cpu_mem_read | cpu_mem_write.
//  - IDLE, host_req & (!cpu_act | wait_cnt==MAX_WAIT): capture addr/len/we, go to BURST.
//    - wait_cnt clears.
//    - If cpu_act that cycle, cpu_stall=1 and the CPU gets no memory access.
//  - IDLE, host_req & cpu_act & wait_cnt<MAX_WAIT: wait_cnt++; CPU is served.
//  - IDLE, !host_req: wait_cnt clears.
//  - BURST: one beat per cycle.
//    - mem_addr=addr_q, mem_we=we_q, mem_re=!we_q, mem_byte_en=0, mem_wdata=host_wdata.
//    - addr_q++ each beat; wraps 255->0 modulo 2^AW.
//    - cpu_stall = cpu_act.
//    - After beat host_len+1, go to DRAIN.
//  - Read beats: host_rvalid=1 one cycle after each beat; host_rdata=mem_rdata.
//  - DRAIN (1 cycle): memory idle; cpu_stall=cpu_act; last rvalid (reads); host_done=1.
//    - Next state is IDLE.
//  - host_req/host_* changes during BURST or DRAIN are ignored.
//    - A request still high in IDLE starts a new burst.
//  - host_len=0: single beat; host_gnt and the beat occur in the same cycle.
//  - rst mid-burst: immediate IDLE; no host_done; pending rvalid dropped.
//  - cpu_mem_read & cpu_mem_write both high: treated as write (mem_re=0).
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    - stat_stall_cnt increments on each cycle with cpu_stall=1.
//    - stat_beat_cnt increments on each BURST cycle.
//    - Both saturate at all-ones and are cleared by rst.
//  Undefined: both outputs tied to 0; no counter flops.
// TESTING
//  1. CPU only: write 0x12345 @0x10, then read @0x10 -> cpu_rdata=0x12345 next cycle;
//     cpu_stall never 1.
//  2. Host write burst, CPU idle: addr=0xFE, len=3, words A,B,C,D ->
//     - gnt on cycle 1, writes to FE,FF,00,01 (wrap);
//     - done on cycle 5.
//  3. Host read burst of 2 at 0x20 ->
//     - rvalid on cycles 2 and 3 with mem[0x20], mem[0x21];
//     - done coincides with the second rvalid.
//  4. Starvation, MAX_WAIT=8: CPU accesses every cycle, host_req held ->
//     - CPU served 8 cycles;
//     - cycle 9: cpu_stall=1 and burst starts.
//  5. Reset pulse during beat 2 of len=5 -> IDLE next edge; no host_done; cpu_stall=0.
//  6. Stats build (DMEM_ARB_STATS_EN) running test 4 with len=3 ->
//     - stat_beat_cnt=4;
//     - stat_stall_cnt=6: grant cycle + 4 BURST + DRAIN.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a host burst port.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BURST_WIDTH   = 8,
    parameter int MAX_WAIT      = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_mem_read,
    input  logic                     cpu_mem_write,
    input  logic                     cpu_byte_en,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDRESS_WIDTH-1:0] host_addr,
    input  logic [BURST_WIDTH-1:0]   host_len,
    input  logic [DATA_WIDTH-1:0]    host_wdata,
    output logic                     host_gnt,
    output logic                     host_rvalid,
    output logic [DATA_WIDTH-1:0]    host_rdata,
    output logic                     host_done,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic                     mem_byte_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [CNT_WIDTH-1:0]     stat_stall_cnt,
    output logic [CNT_WIDTH-1:0]     stat_beat_cnt
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [BURST_WIDTH-1:0]   len_q;
    logic                     we_q;
    logic [WW-1:0]            wait_q;
    logic                     gnt_q;
    logic                     rvalid_q;

    logic cpu_act;
    logic grant;

    assign cpu_act = cpu_mem_read | cpu_mem_write;
    assign grant   = (state_q == IDLE) & host_req & (~cpu_act | (wait_q == WW'(MAX_WAIT)));

    // len_q counts remaining beats down; the beat seen with len_q==0 is the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            wait_q   <= '0;
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            gnt_q    <= 1'b0;
            rvalid_q <= (state_q == BURST) & ~we_q;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        addr_q  <= host_addr;
                        len_q   <= host_len;
                        we_q    <= host_we;
                        wait_q  <= '0;
                        gnt_q   <= 1'b1;
                        state_q <= BURST;
                    end else if (host_req & cpu_act) begin
                        wait_q <= wait_q + 1'b1;
                    end else begin
                        wait_q <= '0;
                    end
                end
                BURST: begin
                    addr_q <= addr_q + 1'b1;
                    if (len_q == '0) begin
                        state_q <= DRAIN;
                    end else begin
                        len_q <= len_q - 1'b1;
                    end
                end
                DRAIN:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_byte_en = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        cpu_stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    cpu_stall = cpu_act;
                end else begin
                    mem_re      = cpu_mem_read & ~cpu_mem_write;
                    mem_we      = cpu_mem_write;
                    mem_byte_en = cpu_byte_en;
                end
            end
            BURST: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_re    = ~we_q;
                mem_wdata = host_wdata;
                cpu_stall = cpu_act;
            end
            DRAIN:   cpu_stall = cpu_act;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign host_gnt    = gnt_q;
    assign host_rvalid = rvalid_q;
    assign host_done   = (state_q == DRAIN);

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] beat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (cpu_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((state_q == BURST) && (beat_cnt_q != '1)) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_beat_cnt  = beat_cnt_q;
`else
    assign stat_stall_cnt = '0;
    assign stat_beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: IDLE pass-through table plus burst,
// starvation and reset sequences against a behavioural 1-cycle-latency memory.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_mem_read, cpu_mem_write, cpu_byte_en;
    logic [7:0]  cpu_addr;
    logic [19:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [7:0]  host_addr, host_len;
    logic [19:0] host_wdata, host_rdata;
    logic        host_gnt, host_rvalid, host_done;
    logic        mem_re, mem_we, mem_byte_en;
    logic [7:0]  mem_addr;
    logic [19:0] mem_wdata, mem_rdata;
    logic [15:0] stat_stall_cnt, stat_beat_cnt;

    logic [19:0] mem [256];

    int nvec = 0;
    int nerr = 0;

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_byte_en(cpu_byte_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_len(host_len), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_done(host_done),
        .mem_re(mem_re), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_stall_cnt(stat_stall_cnt), .stat_beat_cnt(stat_beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        rd, wr, be;
        logic [7:0]  addr;
        logic [19:0] wd;
        logic        ex_re, ex_we, ex_be;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic be,
                       input logic [7:0] a, input logic [19:0] wd);
        cpu_mem_read  = rd;
        cpu_mem_write = wr;
        cpu_byte_en   = be;
        cpu_addr      = a;
        cpu_wdata     = wd;
    endtask

    task automatic host(input logic req, input logic we, input logic [7:0] a, input logic [7:0] len);
        host_req  = req;
        host_we   = we;
        host_addr = a;
        host_len  = len;
    endtask

    initial begin
        logic [19:0] words [4];
        logic [7:0]  waddr [4];
        words[0] = 20'hAAAAA; words[1] = 20'hBBBBB; words[2] = 20'hCCCCC; words[3] = 20'hDDDDD;
        waddr[0] = 8'hFE; waddr[1] = 8'hFF; waddr[2] = 8'h00; waddr[3] = 8'h01;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h80, 20'h00000, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h81, 20'h0ABCD, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h82, 20'h12121, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h83, 20'h33333, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hFF, 20'h00001, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h90, 20'hFFFFF, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        cpu(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        host(1'b0, 1'b0, 8'h00, 8'h00);
        host_wdata = 20'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_gnt", 32'(host_gnt), 32'd0);
        chk("reset_rvalid", 32'(host_rvalid), 32'd0);
        chk("reset_done", 32'(host_done), 32'd0);
        chk("reset_strobes", 32'({mem_re, mem_we}), 32'd0);
        chk("reset_stats", 32'({stat_stall_cnt, stat_beat_cnt}), 32'd0);
        cyc();

        // IDLE pass-through table
        for (int i = 0; i < 6; i++) begin
            cpu(tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].wd);
            settle();
            chk($sformatf("tbl%0d_re", i), 32'(mem_re), 32'(tbl[i].ex_re));
            chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].ex_we));
            chk($sformatf("tbl%0d_be", i), 32'(mem_byte_en), 32'(tbl[i].ex_be));
            chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].wd));
            chk($sformatf("tbl%0d_stall", i), 32'(cpu_stall), 32'd0);
            cyc();
        end

        // CPU write then read back
        cpu(1'b0, 1'b1, 1'b0, 8'h10, 20'h12345);
        settle();
        chk("cpu_wr_we", 32'(mem_we), 32'd1);
        chk("cpu_wr_addr", 32'(mem_addr), 32'h10);
        chk("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        cyc();
        cpu(1'b1, 1'b0, 1'b0, 8'h10, 20'h0);
        settle();
        chk("cpu_rd_re", 32'(mem_re), 32'd1);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        cyc();
        cpu(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
        settle();
        chk("cpu_rdata", 32'(cpu_rdata), 32'h12345);
        cyc();
        for (int i = 0; i < 4; i++) begin
            cpu(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i), 20'h11111 * 20'(i + 1));
            cyc();
        end
        cpu(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);

        // Host write burst with address wrap
        host(1'b1, 1'b1, 8'hFE, 8'd3);
        settle();
        chk("wb_grant_stall", 32'(cpu_stall), 32'd0);
        chk("wb_grant_gnt", 32'(host_gnt), 32'd0);
        cyc();
        host(1'b0, 1'b0, 8'h55, 8'd9);
        for (int i = 0; i < 4; i++) begin
            host_wdata = words[i];
            settle();
            chk($sformatf("wb_beat%0d_we", i), 32'(mem_we), 32'd1);
            chk($sformatf("wb_beat%0d_addr", i), 32'(mem_addr), 32'(waddr[i]));
            chk($sformatf("wb_beat%0d_wdata", i), 32'(mem_wdata), 32'(words[i]));
            chk($sformatf("wb_beat%0d_gnt", i), 32'(host_gnt), 32'(i == 0));
            chk($sformatf("wb_beat%0d_done", i), 32'(host_done), 32'd0);
            cyc();
        end
        settle();
        chk("wb_drain_done", 32'(host_done), 32'd1);
        chk("wb_drain_strobes", 32'({mem_re, mem_we}), 32'd0);
        cyc();
        settle();
        chk("wb_after_done", 32'(host_done), 32'd0);
        cyc();
        for (int j = 0; j < 5; j++) begin
            if (j < 4) cpu(1'b1, 1'b0, 1'b0, waddr[j], 20'h0);
            else cpu(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
            settle();
            if (j > 0) chk($sformatf("wb_readback%0d", j - 1), 32'(cpu_rdata), 32'(words[j - 1]));
            cyc();
        end

        // Host read burst of 2 at 0x20
        host(1'b1, 1'b0, 8'h20, 8'd1);
        settle();
        chk("rb_grant_gnt", 32'(host_gnt), 32'd0);
        cyc();
        host(1'b0, 1'b0, 8'h00, 8'd0);
        settle();
        chk("rb_c1_re", 32'(mem_re), 32'd1);
        chk("rb_c1_addr", 32'(mem_addr), 32'h20);
        chk("rb_c1_gnt", 32'(host_gnt), 32'd1);
        chk("rb_c1_rvalid", 32'(host_rvalid), 32'd0);
        cyc();
        settle();
        chk("rb_c2_addr", 32'(mem_addr), 32'h21);
        chk("rb_c2_rvalid", 32'(host_rvalid), 32'd1);
        chk("rb_c2_rdata", 32'(host_rdata), 32'h11111);
        chk("rb_c2_done", 32'(host_done), 32'd0);
        cyc();
        settle();
        chk("rb_c3_done", 32'(host_done), 32'd1);
        chk("rb_c3_rvalid", 32'(host_rvalid), 32'd1);
        chk("rb_c3_rdata", 32'(host_rdata), 32'h22222);
        chk("rb_c3_re", 32'(mem_re), 32'd0);
        cyc();
        settle();
        chk("rb_c4_rvalid", 32'(host_rvalid), 32'd0);
        chk("rb_c4_done", 32'(host_done), 32'd0);
        cyc();

        // Single-beat burst: grant and beat in the same cycle
        host(1'b1, 1'b0, 8'h23, 8'd0);
        cyc();
        host(1'b0, 1'b0, 8'h00, 8'd0);
        settle();
        chk("len0_gnt", 32'(host_gnt), 32'd1);
        chk("len0_re_addr", 32'({mem_re, mem_addr}), 32'h123);
        cyc();
        settle();
        chk("len0_done", 32'(host_done), 32'd1);
        chk("len0_rdata", 32'({host_rvalid, host_rdata}), 32'h144444);
        cyc();

        // Starvation: clear stats first
        rst = 1'b1;
        settle();
        chk("rst2_stats", 32'({stat_stall_cnt, stat_beat_cnt}), 32'd0);
        cyc();
        rst = 1'b0;
        cpu(1'b1, 1'b0, 1'b0, 8'h21, 20'h0);
        host(1'b1, 1'b0, 8'h20, 8'd3);
        for (int i = 1; i <= 8; i++) begin
            settle();
            chk($sformatf("starve%0d_stall", i), 32'(cpu_stall), 32'd0);
            chk($sformatf("starve%0d_re", i), 32'(mem_re), 32'd1);
            cyc();
        end
        settle();
        chk("starve9_stall", 32'(cpu_stall), 32'd1);
        chk("starve9_re", 32'(mem_re), 32'd0);
        cyc();
        host(1'b0, 1'b0, 8'h00, 8'd0);
        for (int b = 0; b < 4; b++) begin
            settle();
            chk($sformatf("sv_beat%0d_stall", b), 32'(cpu_stall), 32'd1);
            chk($sformatf("sv_beat%0d_addr", b), 32'(mem_addr), 32'(8'h20 + 8'(b)));
            cyc();
        end
        settle();
        chk("sv_drain", 32'({cpu_stall, host_done, mem_re}), 32'b110);
        cyc();
        settle();
        chk("sv_idle", 32'({cpu_stall, host_done, mem_re}), 32'b001);
        cyc();
        cpu(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_beat_cnt", 32'(stat_beat_cnt), 32'd4);
        chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'd6);
`else
        chk("stat_beat_cnt", 32'(stat_beat_cnt), 32'd0);
        chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'd0);
`endif
        cyc();

        // Reset during beat 2 of a read burst
        host(1'b1, 1'b0, 8'h20, 8'd5);
        cyc();
        host(1'b0, 1'b0, 8'h00, 8'd0);
        cyc();
        settle();
        chk("rstmid_rvalid_pre", 32'(host_rvalid), 32'd1);
        chk("rstmid_addr_pre", 32'(mem_addr), 32'h21);
        rst = 1'b1;
        cpu(1'b1, 1'b0, 1'b0, 8'h22, 20'h0);
        #1;
        chk("rstmid_async", 32'({cpu_stall, host_done, host_rvalid}), 32'd0);
        cyc();
        rst = 1'b0;
        settle();
        chk("rstmid_idle", 32'({cpu_stall, host_done, host_rvalid, host_gnt}), 32'd0);
        chk("rstmid_mirror", 32'({mem_re, mem_addr}), 32'h122);
        cyc();
        settle();
        chk("rstmid_nodone", 32'({host_done, host_rvalid}), 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
